// File: rtl/vid_timing_rx.sv
// vid_timing_rx: receive-side video timing meter with lock monitor.
// Optional per-frame pixel CRC when VID_TIMING_RX_CRC_EN is defined.
module vid_timing_rx #(
  parameter int EXP_H_ACTIVE = 1920,
  parameter int EXP_H_TOTAL  = 2200,
  parameter int EXP_V_ACTIVE = 1080,
  parameter int EXP_V_TOTAL  = 1125,
  parameter int HS_POL       = 1,
  parameter int VS_POL       = 1,
  parameter int LOCK_FRAMES  = 2,
  parameter int TIMEOUT_LOG2 = 22
) (
  input  logic        clk_148_5,
  input  logic        reset_n,
  input  logic        vid_hs,
  input  logic        vid_vs,
  input  logic        vid_de,
  input  logic [23:0] vid_rgb,
  input  logic        clear,
  output logic [11:0] meas_h_total,
  output logic [11:0] meas_h_active,
  output logic [11:0] meas_v_total,
  output logic [11:0] meas_v_active,
  output logic        frame_done,
  output logic        frame_match,
  output logic        locked,
  output logic        timeout_flag,
  output logic [7:0]  err_count,
  output logic [15:0] frame_crc
);

  typedef enum logic [1:0] {
    IDLE, MEASURE, LOCKING, LOCKED
  } state_t;

  localparam logic [11:0] SAT  = 12'hFFF;
  localparam logic [11:0] E_HA = 12'(EXP_H_ACTIVE);
  localparam logic [11:0] E_HT = 12'(EXP_H_TOTAL);
  localparam logic [11:0] E_VA = 12'(EXP_V_ACTIVE);
  localparam logic [11:0] E_VT = 12'(EXP_V_TOTAL);
  localparam logic        HP   = 1'(HS_POL);
  localparam logic        VP   = 1'(VS_POL);
  localparam logic [3:0]  LF   = 4'(LOCK_FRAMES);

  function automatic logic [11:0] inc(
    input logic [11:0] v
  );
    return (v == SAT) ? v : v + 12'd1;
  endfunction

  logic hs_r, vs_r, de_r, clr_r;
  logic hs_n, vs_n, hs_d, vs_d;
  logic hs_p, vs_p, de_p;

  logic [11:0] h_cnt, de_cnt, v_cnt;
  logic [11:0] v_act, h_act, h_tot;
  logic        first_done, line_err;

  logic        has_de, first_ln, bad_ln;
  logic        lerr_nx, match_nx;
  logic [11:0] h_act_nx, h_tot_nx;
  logic [11:0] v_act_nx, m_hact;

  logic [TIMEOUT_LOG2-1:0] to_cnt;
  logic                    to_hit;

  state_t     state, state_nx;
  logic [3:0] match_cnt, mc_nx;
  logic       err_inc;

  assign hs_n = (hs_r == HP);
  assign vs_n = (vs_r == VP);

  // Edge pulses are registered so de_p stays aligned
  always_ff @(posedge clk_148_5 or negedge reset_n) begin
    if (!reset_n) begin
      hs_r  <= 1'b0;
      vs_r  <= 1'b0;
      de_r  <= 1'b0;
      clr_r <= 1'b0;
      hs_d  <= 1'b0;
      vs_d  <= 1'b0;
      hs_p  <= 1'b0;
      vs_p  <= 1'b0;
      de_p  <= 1'b0;
    end else begin
      hs_r  <= vid_hs;
      vs_r  <= vid_vs;
      de_r  <= vid_de;
      clr_r <= clear;
      hs_d  <= hs_n;
      vs_d  <= vs_n;
      hs_p  <= hs_n & ~hs_d;
      vs_p  <= vs_n & ~vs_d;
      de_p  <= de_r;
    end
  end

  assign has_de   = |de_cnt;
  assign first_ln = hs_p & has_de & ~first_done;
  assign bad_ln   = hs_p & has_de & first_done
                  & (de_cnt != h_act);
  assign h_act_nx = first_ln ? de_cnt : h_act;
  assign h_tot_nx = hs_p ? h_cnt : h_tot;
  assign v_act_nx = (hs_p & has_de)
                  ? inc(v_act) : v_act;
  assign lerr_nx  = line_err | bad_ln;
  assign m_hact   = (first_done | first_ln)
                  ? h_act_nx : 12'd0;
  assign match_nx = (h_tot_nx == E_HT)
                  & (m_hact == E_HA)
                  & (v_cnt == E_VT)
                  & (v_act_nx == E_VA)
                  & ~lerr_nx;

  always_ff @(posedge clk_148_5 or negedge reset_n) begin
    if (!reset_n) begin
      h_cnt      <= '0;
      de_cnt     <= '0;
      h_tot      <= '0;
      h_act      <= '0;
      v_cnt      <= '0;
      v_act      <= '0;
      line_err   <= 1'b0;
      first_done <= 1'b0;
    end else begin
      h_cnt  <= hs_p ? 12'd1 : inc(h_cnt);
      de_cnt <= hs_p ? {11'd0, de_p}
              : (de_p ? inc(de_cnt) : de_cnt);
      h_tot  <= h_tot_nx;
      h_act  <= h_act_nx;
      // A coincident hs edge opens line 1 of the new frame
      if (vs_p) begin
        v_cnt      <= {11'd0, hs_p};
        v_act      <= '0;
        line_err   <= 1'b0;
        first_done <= 1'b0;
      end else begin
        v_cnt      <= hs_p ? inc(v_cnt) : v_cnt;
        v_act      <= v_act_nx;
        line_err   <= lerr_nx;
        first_done <= first_done | first_ln;
      end
    end
  end

  always_ff @(posedge clk_148_5 or negedge reset_n) begin
    if (!reset_n) begin
      frame_done    <= 1'b0;
      frame_match   <= 1'b0;
      meas_h_total  <= '0;
      meas_h_active <= '0;
      meas_v_total  <= '0;
      meas_v_active <= '0;
    end else begin
      frame_done <= vs_p;
      if (vs_p) begin
        frame_match   <= match_nx;
        meas_h_total  <= h_tot_nx;
        meas_h_active <= m_hact;
        meas_v_total  <= v_cnt;
        meas_v_active <= v_act_nx;
      end
    end
  end

  assign to_hit = (&to_cnt) & ~vs_p & ~clr_r;

  always_ff @(posedge clk_148_5 or negedge reset_n) begin
    if (!reset_n) begin
      to_cnt       <= '0;
      timeout_flag <= 1'b0;
    end else begin
      to_cnt <= (vs_p | clr_r) ? '0
              : to_cnt + TIMEOUT_LOG2'(1);
      if (clr_r)
        timeout_flag <= 1'b0;
      else if (to_hit)
        timeout_flag <= 1'b1;
    end
  end

  always_ff @(posedge clk_148_5 or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      match_cnt <= '0;
      err_count <= '0;
    end else begin
      state     <= state_nx;
      match_cnt <= mc_nx;
      if (clr_r)
        err_count <= '0;
      else if (err_inc && err_count != 8'hFF)
        err_count <= err_count + 8'd1;
    end
  end

  always_comb begin
    state_nx = state;
    mc_nx    = match_cnt;
    err_inc  = 1'b0;
    if (clr_r || to_hit) begin
      state_nx = IDLE;
      mc_nx    = '0;
    end else if (vs_p) begin
      unique case (state)
        IDLE: begin
          state_nx = MEASURE;
          mc_nx    = '0;
        end
        MEASURE: if (match_nx) begin
          state_nx = (LF <= 4'd1) ? LOCKED : LOCKING;
          mc_nx    = 4'd1;
        end
        LOCKING: if (match_nx) begin
          mc_nx = match_cnt + 4'd1;
          if (mc_nx >= LF)
            state_nx = LOCKED;
        end else begin
          state_nx = MEASURE;
          mc_nx    = '0;
        end
        LOCKED: if (!match_nx) begin
          state_nx = MEASURE;
          mc_nx    = '0;
          err_inc  = 1'b1;
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  always_comb begin
    locked = (state == LOCKED);
  end

`ifdef VID_TIMING_RX_CRC_EN
  logic [23:0] rgb_r, rgb_p;
  logic [15:0] crc_q, crc_nx, crc_d;

  always_comb begin
    crc_nx = crc_q;
    for (int i = 23; i >= 0; i--)
      crc_nx = {crc_nx[14:0], 1'b0}
             ^ ({16{crc_nx[15] ^ rgb_p[i]}}
                & 16'h1021);
  end

  assign crc_d = de_p ? crc_nx : crc_q;

  always_ff @(posedge clk_148_5 or negedge reset_n) begin
    if (!reset_n) begin
      rgb_r     <= '0;
      rgb_p     <= '0;
      crc_q     <= 16'hFFFF;
      frame_crc <= '0;
    end else begin
      rgb_r <= vid_rgb;
      rgb_p <= rgb_r;
      if (vs_p) begin
        frame_crc <= crc_d;
        crc_q     <= 16'hFFFF;
      end else begin
        crc_q <= crc_d;
      end
    end
  end
`else
  logic unused_rgb;
  assign unused_rgb = ^vid_rgb;
  assign frame_crc  = '0;
`endif

endmodule
